locking_rr_arbiter_param: RTL and testbench



---
 rtl/locking_rr_arbiter_param_pkg.sv | 21 ++
 rtl/locking_rr_arbiter_param_rr_priority_pick.sv | 40 ++++
 rtl/locking_rr_arbiter_param.sv | 104 ++++++++++
 tb/tb_locking_rr_arbiter_param.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/locking_rr_arbiter_param_pkg.sv
// Shared definitions for the locking round-robin arbiter family:
// width derivations and per-channel payload width defaults.
package locking_rr_arbiter_param_pkg;

  // Default flattened payload widths for the message-network channels.
  localparam int GRANT_DATA_W   = 76;
  localparam int RELEASE_DATA_W = 76;
  localparam int ACQUIRE_DATA_W = 76;
  localparam int DEFAULT_DATA_W = GRANT_DATA_W;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_w_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Beat counter width; a single-beat configuration still keeps one bit.
  function automatic int beats_w_of(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/locking_rr_arbiter_param_rr_priority_pick.sv
// Round-robin priority pick: first valid index above last_grant,
// else the lowest valid index, else N_IN-1. Purely combinational.
module rr_priority_pick
  import locking_rr_arbiter_param_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int IDX_W = idx_w_of(N_IN)
) (
  input  logic [N_IN-1:0]  valid,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] choice
);

  logic             found_hi;
  logic             found_lo;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Scan from the top down so the last hit left standing is the lowest index.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = {IDX_W{1'b0}};
    lo_idx   = {IDX_W{1'b0}};
    for (int i = N_IN - 1; i >= 0; i--) begin
      lo_idx   = valid[i] ? IDX_W'(i) : lo_idx;
      found_lo = found_lo | valid[i];
      hi_idx   = (valid[i] && (IDX_W'(i) > last_grant)) ? IDX_W'(i) : hi_idx;
      found_hi = found_hi | (valid[i] && (IDX_W'(i) > last_grant));
    end
    if (found_hi) begin
      choice = hi_idx;
    end else if (found_lo) begin
      choice = lo_idx;
    end else begin
      choice = IDX_W'(N_IN - 1);
    end
  end

endmodule

// File: rtl/locking_rr_arbiter_param.sv
// N-input locking round-robin arbiter. A message flagged multi-beat holds
// the output on its source until BEATS beats have transferred; otherwise
// the grant pointer rotates on every transfer.
module locking_rr_arbiter_param
  import locking_rr_arbiter_param_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int BEATS  = 8,
  parameter int IDX_W  = idx_w_of(N_IN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_IN-1:0]          io_in_valid,
  output logic [N_IN-1:0]          io_in_ready,
  input  logic [N_IN-1:0]          io_in_multibeat,
  input  logic [N_IN*DATA_W-1:0]   io_in_bits,
  output logic                     io_out_valid,
  input  logic                     io_out_ready,
  output logic [DATA_W-1:0]        io_out_bits,
  output logic [IDX_W-1:0]         io_chosen,
  output logic                     io_locked
);

  localparam int                 BEATS_W   = beats_w_of(BEATS);
  localparam logic               LOCK_EN   = (BEATS > 1);
  localparam logic [BEATS_W-1:0] BEAT_ZERO = {BEATS_W{1'b0}};
  localparam logic [BEATS_W-1:0] BEAT_ONE  = BEATS_W'(1);
  localparam logic [BEATS_W-1:0] LAST_BEAT = BEATS_W'(BEATS - 1);

  logic [BEATS_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;

  logic [IDX_W-1:0]   choice;
  logic [IDX_W-1:0]   chosen;
  logic               locked;
  logic               multibeat_sel;
  logic               fire;

  rr_priority_pick #(
    .N_IN  (N_IN),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid      (io_in_valid),
    .last_grant (last_grant_q),
    .choice     (choice)
  );

  assign locked    = (beat_cnt_q != BEAT_ZERO);
  assign chosen    = locked ? lock_idx_q : choice;
  assign fire      = io_out_valid & io_out_ready;
  assign io_chosen = chosen;
  assign io_locked = locked;

  // Output mux and per-input ready; ready depends only on the selection, never on valid.
  always_comb begin
    io_out_bits   = {DATA_W{1'b0}};
    io_out_valid  = 1'b0;
    multibeat_sel = 1'b0;
    io_in_ready   = {N_IN{1'b0}};
    for (int i = 0; i < N_IN; i++) begin
      io_in_ready[i] = io_out_ready & (chosen == IDX_W'(i));
      io_out_bits    = (chosen == IDX_W'(i)) ? io_in_bits[i*DATA_W +: DATA_W] : io_out_bits;
      io_out_valid   = (chosen == IDX_W'(i)) ? io_in_valid[i] : io_out_valid;
      multibeat_sel  = (chosen == IDX_W'(i)) ? io_in_multibeat[i] : multibeat_sel;
    end
  end

  // Next state: pointer follows every transfer; lock opens on a multi-beat
  // first beat and closes on the transfer of the final beat.
  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    lock_idx_d   = lock_idx_q;
    last_grant_d = last_grant_q;
    if (fire) begin
      last_grant_d = chosen;
      if (locked) begin
        beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? BEAT_ZERO : (beat_cnt_q + BEAT_ONE);
      end else if (LOCK_EN && multibeat_sel) begin
        beat_cnt_d = BEAT_ONE;
        lock_idx_d = chosen;
      end else begin
        beat_cnt_d = beat_cnt_q;
      end
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
  end

  // State registers; reset drops any lock in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt_q   <= BEAT_ZERO;
      lock_idx_q   <= {IDX_W{1'b0}};
      last_grant_q <= {IDX_W{1'b0}};
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      lock_idx_q   <= lock_idx_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_locking_rr_arbiter_param.sv
// Directed bench for locking_rr_arbiter_param: a 4-input/8-beat instance
// and a 2-input/1-beat instance, checked with immediate assertions.
module tb_locking_rr_arbiter_param;

  localparam int N_A  = 4;
  localparam int DW_A = 76;
  localparam int N_B  = 2;
  localparam int DW_B = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N_IN=4, BEATS=8
  logic                  reset;
  logic [N_A-1:0]        in_valid;
  logic [N_A-1:0]        in_ready;
  logic [N_A-1:0]        mb;
  logic [N_A*DW_A-1:0]   in_bits;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW_A-1:0]       out_bits;
  logic [1:0]            chosen;
  logic                  locked;

  // Instance B: N_IN=2, BEATS=1
  logic                  reset_b;
  logic [N_B-1:0]        in_valid_b;
  logic [N_B-1:0]        in_ready_b;
  logic [N_B-1:0]        mb_b;
  logic [N_B*DW_B-1:0]   in_bits_b;
  logic                  out_valid_b;
  logic                  out_ready_b;
  logic [DW_B-1:0]       out_bits_b;
  logic [0:0]            chosen_b;
  logic                  locked_b;

  int checks   = 0;
  int failures = 0;

  locking_rr_arbiter_param #(.N_IN(N_A), .DATA_W(DW_A), .BEATS(8)) dut_a (
    .clk(clk), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(in_ready), .io_in_multibeat(mb),
    .io_in_bits(in_bits), .io_out_valid(out_valid), .io_out_ready(out_ready),
    .io_out_bits(out_bits), .io_chosen(chosen), .io_locked(locked)
  );

  locking_rr_arbiter_param #(.N_IN(N_B), .DATA_W(DW_B), .BEATS(1)) dut_b (
    .clk(clk), .reset(reset_b),
    .io_in_valid(in_valid_b), .io_in_ready(in_ready_b), .io_in_multibeat(mb_b),
    .io_in_bits(in_bits_b), .io_out_valid(out_valid_b), .io_out_ready(out_ready_b),
    .io_out_bits(out_bits_b), .io_chosen(chosen_b), .io_locked(locked_b)
  );

  function automatic logic [DW_A-1:0] pay_a(input int idx);
    logic [3:0] n;
    n = 4'(idx + 5);
    return {19{n}};
  endfunction

  function automatic logic [DW_B-1:0] pay_b(input int idx);
    logic [3:0] n;
    n = 4'(idx + 9);
    return {n, ~n};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_a(input string tag, input int ch, input logic v, input logic lk);
    logic [N_A-1:0] er;
    er = out_ready ? (4'b0001 << ch) : 4'b0000;
    chk({tag, ".chosen"}, 128'(chosen), 128'(ch));
    chk({tag, ".valid"},  128'(out_valid), 128'(v));
    chk({tag, ".locked"}, 128'(locked), 128'(lk));
    chk({tag, ".ready"},  128'(in_ready), 128'(er));
    chk({tag, ".bits"},   128'(out_bits), 128'(pay_a(ch)));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq_a[5];
    int seq_b[4];
    seq_a = '{1, 2, 3, 0, 1};
    seq_b = '{1, 0, 1, 0};

    reset = 1'b1; in_valid = 4'b0000; mb = 4'b0000; out_ready = 1'b0;
    reset_b = 1'b1; in_valid_b = 2'b00; mb_b = 2'b00; out_ready_b = 1'b0;
    for (int i = 0; i < N_A; i++) in_bits[i*DW_A +: DW_A] = pay_a(i);
    for (int i = 0; i < N_B; i++) in_bits_b[i*DW_B +: DW_B] = pay_b(i);
    tick;
    tick;

    // Reset state, nothing valid: choice defaults to N_IN-1
    #2 expect_a("reset", 3, 1'b0, 1'b0);

    // Single-beat rotation from last_grant=0
    reset = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #2 expect_a("rotate", seq_a[k], 1'b1, 1'b0);
      tick;
    end

    // Lock on input 2 (last_grant=1): 8 fires, then input 3
    mb = 4'b0100;
    #2 expect_a("lock2_first", 2, 1'b1, 1'b0);
    tick;
    mb = 4'b0000;
    for (int k = 0; k < 7; k++) begin
      #2 expect_a("lock2_beat", 2, 1'b1, 1'b1);
      tick;
    end
    #2 expect_a("lock2_release", 3, 1'b1, 1'b0);
    tick;

    // Lock on input 1, stall 5 cycles at beat 3, then finish
    in_valid = 4'b0010; mb = 4'b0010;
    #2 expect_a("lock1_first", 1, 1'b1, 1'b0);
    tick;
    in_valid = 4'b1111; mb = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      #2 expect_a("lock1_beat", 1, 1'b1, 1'b1);
      tick;
    end
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #2 expect_a("lock1_stall", 1, 1'b1, 1'b1);
      tick;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #2 expect_a("lock1_rest", 1, 1'b1, 1'b1);
      tick;
    end
    #2 expect_a("lock1_release", 2, 1'b1, 1'b0);
    tick;

    // Lock on input 0 while it drops valid for 2 cycles
    in_valid = 4'b0001; mb = 4'b0001;
    #2 expect_a("lock0_first", 0, 1'b1, 1'b0);
    tick;
    in_valid = 4'b1110; mb = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      #2 expect_a("lock0_gap", 0, 1'b0, 1'b1);
      tick;
    end
    in_valid = 4'b1111;
    for (int k = 0; k < 7; k++) begin
      #2 expect_a("lock0_beat", 0, 1'b1, 1'b1);
      tick;
    end
    out_ready = 1'b0;
    #2 expect_a("lock0_release", 1, 1'b1, 1'b0);
    tick;

    // Lock on input 3 to beat 5, then reset mid-lock
    out_ready = 1'b1; in_valid = 4'b1000; mb = 4'b1000;
    #2 expect_a("lock3_first", 3, 1'b1, 1'b0);
    tick;
    in_valid = 4'b1111; mb = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      #2 expect_a("lock3_beat", 3, 1'b1, 1'b1);
      tick;
    end
    reset = 1'b1;
    tick;
    reset = 1'b0; out_ready = 1'b0; in_valid = 4'b1010;
    #2 expect_a("post_reset_13", 1, 1'b1, 1'b0);
    in_valid = 4'b0101;
    #2 expect_a("post_reset_02", 2, 1'b1, 1'b0);
    tick;

    // BEATS=1 instance: multibeat ignored, strict alternation
    in_valid_b = 2'b11; mb_b = 2'b11; out_ready_b = 1'b1; reset_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("b.chosen", 128'(chosen_b), 128'(seq_b[k]));
      chk("b.locked", 128'(locked_b), 128'(1'b0));
      chk("b.valid",  128'(out_valid_b), 128'(1'b1));
      chk("b.ready",  128'(in_ready_b), 128'(2'b01 << seq_b[k]));
      chk("b.bits",   128'(out_bits_b), 128'(pay_b(seq_b[k])));
      tick;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
